meter_ctrl: RTL
===============

Name: meter_ctrl

Overview:
Controller for the 4-digit cascaded BCD down-counter of the traffic meter.
- Turns button presses and switch edges into BCD load values, then sequences the counter's LOAD.
- Generates the 1 Hz decrement ENABLE and the display BLANK (flash) control.
- Sits between the raw B0-B3/SW0/SW1 inputs and the four counters. It reads back Q1-Q4 and drives D1-D4, LOAD and ENABLE.

Parameters:
- TICK_DIV, 100000000: CLK cycles per 1 s decrement tick; must be even and >= 4.
- ADD0, 16'h0010: BCD seconds added by B0.
- ADD1, 16'h0180: BCD seconds added by B1.
- ADD2, 16'h0200: BCD seconds added by B2.
- ADD3, 16'h0550: BCD seconds added by B3.
- PRE0, 16'h0010: BCD preset loaded on SW0 rising edge.
- PRE1, 16'h0205: BCD preset loaded on SW1 rising edge.
- LOW_THRESH, 16'h0200: BCD count below which the display flashes at the slow rate.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- CLR  in  1  synchronous, active-high reset.
- B0, B1, B2, B3  in  1 each  add-time buttons, level (debounced upstream).
- SW0, SW1  in  1 each  preset switches, level.
- Q1, Q2, Q3, Q4  in  4 each  current BCD digits (Q1 = ones, Q4 = thousands).
- D1, D2, D3, D4  out  4 each  BCD load value to the counters.
- LOAD  out  1  one-cycle counter load strobe.
- ENABLE  out  1  one-cycle decrement strobe into the ones counter.
- BLANK  out  1  1 = display digits dark.
- BUSY  out  1  1 while in CALC or LOAD.

Behaviour:
- Reset (CLR=1 at a clock edge):
  - state=RUN; D1-D4=0; LOAD=0; ENABLE=0; BLANK=0; BUSY=0.
  - Prescaler=0; tick_pend=0; half-phase=0; edge-detect registers loaded with current B/SW levels, so no spurious edge after reset.
  - CLR mid-sequence aborts CALC/LOAD; no LOAD is issued.
- Edge detection: request = input high this cycle and low the previous cycle.
  - Priority for simultaneous edges: SW1 > SW0 > B3 > B2 > B1 > B0.
  - Only the winner is served; losers are dropped.
  - Edges arriving while BUSY=1 are dropped.
- State machine (RUN, CALC, LOAD):
  - RUN: on a request at cycle t, latch the operand and go to CALC at t+1.
  - CALC: register D = sat9999(Q + addend) for buttons, or D = preset for switches; go to LOAD.
  - LOAD: LOAD=1 for exactly this one cycle, so the counters take D at the end of cycle t+2; return to RUN.
  - Request-to-new-count latency: 3 clock edges.
- BCD add: digit-serial ripple; a digit sum above 9 adds 6 and carries to the next digit. A carry out of Q4 saturates the result to 9999.
- Prescaler: free-running 0..TICK_DIV-1 in every state; a tick occurs on wrap.
  - RUN: a tick asserts ENABLE for one cycle, but only if {Q4,Q3,Q2,Q1} != 0. The counter never wraps below 0000.
  - CALC/LOAD: ENABLE is forced 0 and a tick sets tick_pend. tick_pend issues ENABLE on the first RUN cycle (same nonzero rule), then clears. At most one tick is pending; CLR clears it.
- BLANK: the count compare is a 16-bit unsigned compare, valid for BCD ordering.
  - Count = 0: BLANK toggles every TICK_DIV/2 cycles (0.5 s on / 0.5 s off).
  - 0 < count < LOW_THRESH: BLANK toggles on each tick (1 s on / 1 s off).
  - count >= LOW_THRESH: BLANK = 0.
  - On entering a new flash band, BLANK restarts at 0.

Decomposition:
- Package meter_pkg holds:
  - the state encoding (RUN, CALC, LOAD);
  - 16'h9999 saturation constant;
  - request-select encoding (REQ_NONE, REQ_B0..REQ_B3, REQ_SW0, REQ_SW1).
- Sub-module bcd_add4_sat: combinational 4-digit BCD adder with saturation to 9999, instantiated once.

Test Plan (TICK_DIV=8 in all scenarios):
- CLR then B1 pulse with Q=0000 → LOAD high exactly 2 cycles after the edge cycle; D=0180; BUSY high for 2 cycles.
- Q=9800, B3 edge → D=9999 (saturated); Q=0995, B0 edge → D=1005 (double BCD carry).
- SW1 and B3 rising in the same cycle → only PRE1 served, D=0205; B3 dropped with no second LOAD.
- Q=0003 in RUN → ENABLE pulses every 8 cycles; once Q=0000 no further ENABLE; BLANK toggles every 4 cycles.
- Prescaler wrap during CALC → ENABLE=0 during CALC/LOAD; one ENABLE pulse on the first RUN cycle after LOAD.
- CLR asserted during CALC → no LOAD pulse; all outputs 0 next cycle; a held button does not retrigger after reset.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared types and constants for the traffic-meter controller.
//   state_e : controller sequencing states
//   req_e   : winning input-edge request
//   band_e  : display flash band derived from the current count
package meter_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_CALC, ST_LOAD} state_e;

  typedef enum logic [2:0] {
    REQ_NONE, REQ_B0, REQ_B1, REQ_B2, REQ_B3, REQ_SW0, REQ_SW1
  } req_e;

  typedef enum logic [1:0] {BAND_ZERO, BAND_LOW, BAND_OFF} band_e;

  localparam logic [15:0] BCD_SAT = 16'h9999;

endpackage

// File: rtl/meter_ctrl_bcd_add4_sat.sv
// 4-digit BCD adder, saturating at 9999.
//   a, b : 4-digit BCD operands
//   sum  : a + b in BCD, or 9999 on carry out of the thousands digit
module bcd_add4_sat
  import meter_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [4:0]  dsum;
  logic        carry;
  logic [15:0] raw;

  // Digit-serial ripple: a digit total above 9 is corrected by +6 and
  // carries into the next digit.
  always_comb begin
    dsum  = '0;
    carry = 1'b0;
    raw   = '0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      raw[4*i +: 4] = dsum[3:0];
    end
    sum = carry ? BCD_SAT : raw;
  end

endmodule

// File: rtl/meter_ctrl.sv
// Controller for the 4-digit cascaded BCD down-counter of the traffic meter.
//   CLK, CLR       : clock, synchronous active-high reset
//   B0..B3, SW0/1  : add-time buttons and preset switches (levels)
//   Q1..Q4         : current count digits (Q1 = ones)
//   D1..D4         : load value for the counters
//   LOAD           : one-cycle counter load strobe
//   ENABLE         : one-cycle decrement strobe
//   BLANK          : display dark when 1
//   BUSY           : high while a request is being sequenced
module meter_ctrl
  import meter_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter logic [15:0] ADD0       = 16'h0010,
  parameter logic [15:0] ADD1       = 16'h0180,
  parameter logic [15:0] ADD2       = 16'h0200,
  parameter logic [15:0] ADD3       = 16'h0550,
  parameter logic [15:0] PRE0       = 16'h0010,
  parameter logic [15:0] PRE1       = 16'h0205,
  parameter logic [15:0] LOW_THRESH = 16'h0200
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       B0,
  input  logic       B1,
  input  logic       B2,
  input  logic       B3,
  input  logic       SW0,
  input  logic       SW1,
  input  logic [3:0] Q1,
  input  logic [3:0] Q2,
  input  logic [3:0] Q3,
  input  logic [3:0] Q4,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic [3:0] D4,
  output logic       LOAD,
  output logic       ENABLE,
  output logic       BLANK,
  output logic       BUSY
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2 - 1);

  state_e        state, state_nxt;
  req_e          req, req_q;
  band_e         band, band_q;
  logic [5:0]    lvl, lvl_prev, rise;
  logic [PW-1:0] pres;
  logic          tick, half_tick, tick_pend, blank_q;
  logic [15:0]   count, addend, sum, d_q;

  assign count = {Q4, Q3, Q2, Q1};
  assign lvl   = {SW1, SW0, B3, B2, B1, B0};
  assign rise  = lvl & ~lvl_prev;

  // Highest bit of rise wins; the rest are simply dropped.
  always_comb begin
    req = REQ_NONE;
    if      (rise[5]) req = REQ_SW1;
    else if (rise[4]) req = REQ_SW0;
    else if (rise[3]) req = REQ_B3;
    else if (rise[2]) req = REQ_B2;
    else if (rise[1]) req = REQ_B1;
    else if (rise[0]) req = REQ_B0;
  end

  always_comb begin
    case (req_q)
      REQ_B1:  addend = ADD1;
      REQ_B2:  addend = ADD2;
      REQ_B3:  addend = ADD3;
      default: addend = ADD0;
    endcase
  end

  bcd_add4_sat u_add (.a(count), .b(addend), .sum(sum));

  always_ff @(posedge CLK) begin
    if (CLR) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Edges seen outside RUN never leave RUN, so they are lost by design.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (req != REQ_NONE) state_nxt = ST_CALC;
      ST_CALC: state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign tick      = (pres == PRE_LAST);
  assign half_tick = tick || (pres == PRE_HALF);

  always_comb begin
    if (count == 16'h0)           band = BAND_ZERO;
    else if (count < LOW_THRESH)  band = BAND_LOW;
    else                          band = BAND_OFF;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      req_q     <= REQ_NONE;
      lvl_prev  <= lvl;   // held inputs do not register as edges after reset
      d_q       <= '0;
      pres      <= '0;
      tick_pend <= 1'b0;
      blank_q   <= 1'b0;
      band_q    <= BAND_OFF;
    end else begin
      lvl_prev <= lvl;
      if (state == ST_RUN && req != REQ_NONE) req_q <= req;
      if (state == ST_CALC) begin
        case (req_q)
          REQ_SW1: d_q <= PRE1;
          REQ_SW0: d_q <= PRE0;
          default: d_q <= sum;
        endcase
      end
      pres <= tick ? '0 : pres + PW'(1);
      // A tick during CALC/LOAD is held and spent on the first RUN cycle.
      if (state != ST_RUN) begin
        if (tick) tick_pend <= 1'b1;
      end else begin
        tick_pend <= 1'b0;
      end
      // Changing band restarts the flash with the display lit.
      if (band != band_q) blank_q <= 1'b0;
      else begin
        case (band)
          BAND_ZERO: if (half_tick) blank_q <= ~blank_q;
          BAND_LOW:  if (tick)      blank_q <= ~blank_q;
          default:   blank_q <= 1'b0;
        endcase
      end
      band_q <= band;
    end
  end

  assign {D4, D3, D2, D1} = d_q;
  assign LOAD   = (state == ST_LOAD);
  assign BUSY   = (state != ST_RUN);
  assign ENABLE = (state == ST_RUN) && (tick || tick_pend) && (count != 16'h0);
  assign BLANK  = blank_q;

endmodule
